// File: rtl/zeroriscy_defines.sv
// Shared EX-stage definitions: mult/div operator encodings and divider FSM states.
// Imported by the mult/div datapath blocks.
package zeroriscy_defines;

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ITER,
        DIV_FINISH
    } div_state_t;

endpackage

// File: rtl/zeroriscy_div_unit.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, quotient or remainder.
// Latency: WIDTH+1 cycles from accept to ready_o; 1 cycle for early-out special cases.
// Ports: clk/rst_n; en_i start (IDLE only), kill_i flush; operator_i/signed_i/op_a_i/op_b_i
// operands; busy_o (not IDLE), ready_o (one-cycle result strobe), result_o (held until next result).
module zeroriscy_div_unit
    import zeroriscy_defines::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             kill_i,
    input  logic [1:0]       operator_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH-1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder magnitude
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] b_q, b_d;          // divisor magnitude
    logic             rem_sel_q, rem_sel_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operand decode at start
    logic             a_neg, b_neg, b_zero, sgn_ovf;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign a_neg   = signed_i & op_a_i[WIDTH-1];
    assign b_neg   = signed_i & op_b_i[WIDTH-1];
    assign a_abs   = a_neg ? (~op_a_i + ONE_W) : op_a_i;
    assign b_abs   = b_neg ? (~op_b_i + ONE_W) : op_b_i;
    assign b_zero  = (op_b_i == '0);
    assign sgn_ovf = signed_i & (op_a_i == MIN_VAL) & (op_b_i == '1);

    // Restoring step: the shifted remainder needs WIDTH+1 bits since it can reach 2*|b|-1
    logic [WIDTH:0] shift_rem, trial;
    logic           trial_ge;

    assign shift_rem = {rem_q, quo_q[WIDTH-1]};
    assign trial     = shift_rem - {1'b0, b_q};
    assign trial_ge  = ~trial[WIDTH];

    // Sign fix-up. Divide-by-zero forces an all-ones quotient regardless of operand signs;
    // the remainder magnitude is |a| in that case so taking the sign of a restores a.
    // MIN/-1 falls out naturally: magnitude 2^(WIDTH-1) negates to itself.
    logic [WIDTH-1:0] fin_quo, fin_rem, fin_res;

    assign fin_quo = div_zero_q ? '1 : (neg_quo_q ? (~quo_q + ONE_W) : quo_q);
    assign fin_rem = neg_rem_q ? (~rem_q + ONE_W) : rem_q;
    assign fin_res = rem_sel_q ? fin_rem : fin_quo;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        b_d        = b_q;
        rem_sel_d  = rem_sel_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;

        if (kill_i) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (en_i) begin
                        quo_d      = a_abs;
                        b_d        = b_abs;
                        rem_d      = '0;
                        cnt_d      = CNT_TOP;
                        rem_sel_d  = (operator_i == MD_OP_REM);
                        neg_quo_d  = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        div_zero_d = b_zero;
                        state_d    = DIV_ITER;
                        // Preload magnitudes so the normal fix-up yields the special result
                        if (EARLY_OUT && (b_zero || sgn_ovf)) begin
                            rem_d   = b_zero ? a_abs : '0;
                            state_d = DIV_FINISH;
                        end
                    end
                end
                DIV_ITER: begin
                    rem_d = trial_ge ? trial[WIDTH-1:0] : shift_rem[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], trial_ge};
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == '0) begin
                        state_d = DIV_FINISH;
                    end
                end
                DIV_FINISH: begin
                    result_d = fin_res;
                    state_d  = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            b_q        <= '0;
            rem_sel_q  <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            b_q        <= b_d;
            rem_sel_q  <= rem_sel_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
        end
    end

    // The fresh result is presented during FINISH itself; a same-cycle kill hides it
    assign busy_o   = (state_q != DIV_IDLE);
    assign ready_o  = (state_q == DIV_FINISH) & ~kill_i;
    assign result_o = ready_o ? fin_res : result_q;

endmodule

// File: tb/tb_zeroriscy_div_unit.sv
module tb_zeroriscy_div_unit;
    import zeroriscy_defines::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en32 = 1'b0, en32n = 1'b0, en8 = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  opc = MD_OP_DIV;
    logic        sgn = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;

    logic        busy32, rdy32, busy32n, rdy32n, busy8, rdy8;
    logic [31:0] res32, res32n;
    logic [7:0]  res8;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res[3] = '{32'h0, 32'h0, 32'h0};

    always #5 clk = ~clk;

    zeroriscy_div_unit #(.WIDTH(32), .EARLY_OUT(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .en_i(en32), .kill_i(kill), .operator_i(opc),
        .signed_i(sgn), .op_a_i(a32), .op_b_i(b32),
        .busy_o(busy32), .ready_o(rdy32), .result_o(res32));

    zeroriscy_div_unit #(.WIDTH(32), .EARLY_OUT(1'b0)) dut32n (
        .clk(clk), .rst_n(rst_n), .en_i(en32n), .kill_i(kill), .operator_i(opc),
        .signed_i(sgn), .op_a_i(a32), .op_b_i(b32),
        .busy_o(busy32n), .ready_o(rdy32n), .result_o(res32n));

    zeroriscy_div_unit #(.WIDTH(8), .EARLY_OUT(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .en_i(en8), .kill_i(kill), .operator_i(opc),
        .signed_i(sgn), .op_a_i(a32[7:0]), .op_b_i(b32[7:0]),
        .busy_o(busy8), .ready_o(rdy8), .result_o(res8));

    function automatic logic get_rdy(input int inst);
        case (inst)
            0:       return rdy32;
            1:       return rdy32n;
            default: return rdy8;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0:       return busy32;
            1:       return busy32n;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int inst);
        case (inst)
            0:       return res32;
            1:       return res32n;
            default: return {24'h0, res8};
        endcase
    endfunction

    task automatic set_en(input int inst, input logic v);
        case (inst)
            0:       en32 = v;
            1:       en32n = v;
            default: en8 = v;
        endcase
    endtask

    function automatic logic [31:0] width_mask(input int w);
        logic [32:0] m;
        m = (33'h1 << w) - 33'h1;
        return m[31:0];
    endfunction

    // Reference model: RISC-V M semantics on w-bit operands using 64-bit integer math
    function automatic logic [31:0] model(input int w, input bit is_rem, input bit sg,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] t;
        logic [31:0] mask;
        mask = width_mask(w);
        if (b == 32'h0) return is_rem ? a : mask;
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
        if (sg) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
            if (sa == -(longint'(1) << (w-1)) && sb == -1) return is_rem ? 32'h0 : a;
        end
        q = sa / sb;
        r = sa % sb;
        t = is_rem ? r : q;
        return t[31:0] & mask;
    endfunction

    // Wait for ready_o (cycle 1 = first cycle after the accepting edge), pop and compare
    task automatic wait_result(input int inst, input int exp_lat, input string name);
        int          k;
        logic [31:0] exp_r;
        k = 1;
        while (!get_rdy(inst) && k < 100) begin
            @(negedge clk);
            k++;
        end
        exp_r = exp_q.pop_front();
        n_checks++;
        if (get_rdy(inst) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: no ready_o within %0d cycles, expected result %h", name, k, exp_r);
        end else begin
            if (k !== exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d cycles, expected %0d", name, k, exp_lat);
            end
            n_checks++;
            if (get_res(inst) !== exp_r) begin
                n_fail++;
                $display("FAIL %s result: got %h, expected %h", name, get_res(inst), exp_r);
            end
            last_res[inst] = exp_r;
        end
    endtask

    task automatic do_op(input int inst, input logic [1:0] op, input bit sg,
                         input logic [31:0] a, input logic [31:0] b, input string name);
        int          w, exp_lat;
        bit          eo, special;
        logic [31:0] mask, am, bm;
        w    = (inst == 2) ? 8 : 32;
        eo   = (inst != 1);
        mask = width_mask(w);
        am   = a & mask;
        bm   = b & mask;
        special = (bm == 32'h0) || (sg && am == (32'h1 << (w-1)) && bm == mask);
        exp_lat = (eo && special) ? 1 : w + 1;
        exp_q.push_back(model(w, op == MD_OP_REM, sg, am, bm));
        @(negedge clk);
        n_checks++;
        if (get_busy(inst) !== 1'b0 || get_rdy(inst) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle before start: busy=%b ready=%b, expected 0 0",
                     name, get_busy(inst), get_rdy(inst));
        end
        opc = op; sgn = sg; a32 = am; b32 = bm;
        set_en(inst, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_en(inst, 1'b0);
        wait_result(inst, exp_lat, name);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, expected 0", busy32); end
        n_checks++;
        if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b, expected 0", rdy32); end
        n_checks++;
        if (res32 !== 32'h0) begin n_fail++; $display("FAIL reset result: got %h, expected 0", res32); end
        n_checks++;
        if (res8 !== 8'h0 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL reset w8: result=%h busy=%b, expected 0 0", res8, busy8);
        end
    endtask

    task automatic test_unsigned;
        do_op(0, MD_OP_DIV, 1'b0, 32'd100, 32'd7, "udiv_100_7");
        do_op(0, MD_OP_REM, 1'b0, 32'd100, 32'd7, "urem_100_7");
        do_op(0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd16, "udiv_other_opcode");
    endtask

    task automatic test_signed;
        do_op(0, MD_OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7_2");
        do_op(0, MD_OP_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, "srem_m7_2");
        do_op(0, MD_OP_REM, 1'b1, 32'd7, 32'hFFFF_FFFE, "srem_7_m2");
        do_op(0, MD_OP_DIV, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, "sdiv_m100_m7");
    endtask

    task automatic test_div_zero;
        do_op(0, MD_OP_DIV, 1'b0, 32'd5, 32'd0, "div0_eo");
        do_op(0, MD_OP_REM, 1'b0, 32'd5, 32'd0, "rem0_eo");
        do_op(1, MD_OP_DIV, 1'b0, 32'd5, 32'd0, "div0_iter");
        do_op(1, MD_OP_REM, 1'b0, 32'd5, 32'd0, "rem0_iter");
        do_op(1, MD_OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, "sdiv0_neg_iter");
        do_op(0, MD_OP_REM, 1'b1, 32'hFFFF_FFFB, 32'd0, "srem0_neg_eo");
    endtask

    task automatic test_overflow;
        do_op(0, MD_OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_div_eo");
        do_op(0, MD_OP_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_rem_eo");
        do_op(1, MD_OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_div_iter");
        do_op(1, MD_OP_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_rem_iter");
        do_op(0, MD_OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_operands_unsigned");
    endtask

    task automatic test_kill;
        int k;
        // Kill mid-ITER at cycle 10, restart in cycle 11
        @(negedge clk);
        opc = MD_OP_DIV; sgn = 1'b0; a32 = 32'd1000; b32 = 32'd3; en32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en32 = 1'b0;
        k = 1;
        while (k < 10) begin @(negedge clk); k++; end
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        n_checks++;
        if (busy32 !== 1'b0 || rdy32 !== 1'b0) begin
            n_fail++; $display("FAIL kill_iter state: busy=%b ready=%b, expected 0 0", busy32, rdy32);
        end
        n_checks++;
        if (res32 !== last_res[0]) begin
            n_fail++; $display("FAIL kill_iter result held: got %h, expected %h", res32, last_res[0]);
        end
        exp_q.push_back(32'd3);
        a32 = 32'd9; b32 = 32'd3; en32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en32 = 1'b0;
        wait_result(0, 33, "after_kill_9_3");

        // Kill during FINISH together with en_i: no ready, no restart, result held
        @(negedge clk);
        a32 = 32'd20; b32 = 32'd4; en32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en32 = 1'b0;
        k = 1;
        while (k < 32) begin @(negedge clk); k++; end
        @(posedge clk);
        #1;
        kill = 1'b1; en32 = 1'b1;
        #1;
        n_checks++;
        if (rdy32 !== 1'b0) begin n_fail++; $display("FAIL kill_finish ready: got %b, expected 0", rdy32); end
        n_checks++;
        if (res32 !== last_res[0]) begin
            n_fail++; $display("FAIL kill_finish result held: got %h, expected %h", res32, last_res[0]);
        end
        @(posedge clk);
        #1;
        kill = 1'b0; en32 = 1'b0;
        n_checks++;
        if (busy32 !== 1'b0 || rdy32 !== 1'b0) begin
            n_fail++; $display("FAIL kill_finish no start: busy=%b ready=%b, expected 0 0", busy32, rdy32);
        end
    endtask

    task automatic test_reset_mid_iter;
        @(negedge clk);
        opc = MD_OP_DIV; sgn = 1'b0; a32 = 32'd50; b32 = 32'd5; en32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en32 = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy32 !== 1'b0 || rdy32 !== 1'b0 || res32 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b ready=%b result=%h, expected 0 0 0", busy32, rdy32, res32);
        end
        last_res = '{32'h0, 32'h0, 32'h0};
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_width8;
        do_op(2, MD_OP_DIV, 1'b0, 32'hF0, 32'h03, "w8_udiv_f0_3");
        do_op(2, MD_OP_DIV, 1'b1, 32'h80, 32'hFF, "w8_ovf_div");
        do_op(2, MD_OP_REM, 1'b1, 32'h85, 32'h07, "w8_srem");
    endtask

    // Ops issued the cycle after each result, random operands incl. special cases
    task automatic test_back_to_back;
        logic [31:0] a, b;
        logic [1:0]  op;
        bit          sg;
        int          inst;
        for (int i = 0; i < 30; i++) begin
            inst = (i % 6 == 5) ? 0 : 2;
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = (inst == 2) ? 32'h80 : 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'h1;
                default: ;
            endcase
            do_op(inst, op, sg, a, b, "b2b_random");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_kill();
        test_reset_mid_iter();
        test_width8();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
